// File: rtl/wall_clock_pkg.sv
// Shared types and limits for the wall clock: mode encoding, BCD rollover
// points, and the BCD increment helper used by both the run and set paths.
package wall_clock_pkg;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;

  typedef enum logic [1:0] {
    RUN     = MODE_RUN,
    SET_HR  = MODE_SET_HR,
    SET_MIN = MODE_SET_MIN
  } mode_e;

  localparam logic [7:0] HR_MAX_BCD  = 8'h23;
  localparam logic [7:0] MIN_MAX_BCD = 8'h59;
  localparam logic [5:0] SEC_MAX     = 6'd59;

  // Returns {wrapped, next_bcd}; wraps to 00 once the two-digit limit is reached.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] r;
    if (v == lim)
      r = 9'h100;
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, level debouncer, and a
// registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive samples differing from the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/wall_clock_ctrl.sv
// 24-hour BCD wall clock with a two-button set interface (mode, increment)
// and a blink strobe for the field being edited.
module wall_clock_ctrl
  import wall_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic [2:0] button,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink,
  output logic [5:0] LED
);

  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  mode_e         mode_q, mode_d;
  logic          mode_press, inc_press, tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d;
  logic [8:0]    hr_inc, min_inc;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          unused_btn;

  assign unused_btn = button[2];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk(CLK100MHZ), .rst_n(RESET_N), .btn_in(button[0]), .press(mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk(CLK100MHZ), .rst_n(RESET_N), .btn_in(button[1]), .press(inc_press)
  );

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) mode_q <= RUN;
    else          mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        default: mode_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q     <= '0;
      sec_q       <= '0;
      hr_q        <= '0;
      min_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // A mode press wins over a same-cycle increment press.
  always_comb begin
    hr_inc  = bcd_inc(hr_q, HR_MAX_BCD);
    min_inc = bcd_inc(min_q, MIN_MAX_BCD);
    tick    = (mode_q == RUN) && (presc_q == PW'(CLK_HZ - 1));
    presc_d = '0;
    sec_d   = sec_q;
    hr_d    = hr_q;
    min_d   = min_q;
    case (mode_q)
      RUN: begin
        if (tick) begin
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            min_d = min_inc[7:0];
            if (min_inc[8]) hr_d = hr_inc[7:0];
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      SET_HR: begin
        if (inc_press && !mode_press) hr_d = hr_inc[7:0];
      end
      default: begin
        if (inc_press && !mode_press) min_d = min_inc[7:0];
        if (mode_press) sec_d = '0;
      end
    endcase
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (mode_q != RUN && mode_d == mode_q) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  always_comb begin
    mode      = mode_q;
    hr_tens   = hr_q[7:4];
    hr_units  = hr_q[3:0];
    min_tens  = min_q[7:4];
    min_units = min_q[3:0];
    sec       = sec_q;
    LED       = sec_q;
    blink     = blink_q;
  end

endmodule

// File: doc/wall_clock_ctrl.md
WALL_CLOCK_CTRL -- requirements
Module: wall_clock_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, the clock cycles per second tick.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, the stable-sample count for a button (10 ms).
REQ-003 SHALL have parameter BLINK_CYCLES, default 25_000_000, the half-period of the set-mode blink.
REQ-004 SHALL have port CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port button  in  3  raw asynchronous push-buttons: [0] mode, [1] increment, [2] unused by this block.
REQ-007 SHALL have ports hr_tens, hr_units, min_tens, min_units  out  4 each  BCD time digits.
REQ-008 SHALL have port sec  out  6  binary seconds, 0..59.
REQ-009 SHALL have port mode  out  2  current state encoding: RUN=0, SET_HR=1, SET_MIN=2.
REQ-010 SHALL have port blink  out  1  display-blank strobe for the field being edited.
REQ-011 SHALL have port LED  out  6  equal to sec.

Function
REQ-012 SHALL pass button[0] and button[1] through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 SHALL produce a one-cycle press pulse on each accepted 0->1 transition; releases produce no pulse.
REQ-014 SHALL run the prescaler 0..CLK_HZ-1 in RUN only, asserting tick in the cycle where the count equals CLK_HZ-1, then wrapping to 0.
REQ-015 SHALL update the time registers in the cycle after tick, giving 1-cycle latency to the outputs.
REQ-016 SHALL count sec 0..59; at 59 plus tick, sec SHALL become 0 and minutes SHALL carry.
REQ-017 SHALL count minutes in BCD 00..59 and hours in BCD 00..23, so that 23:59:59 plus tick becomes 00:00:00.
REQ-018 SHALL implement the FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing on each mode press.
REQ-019 SHALL, in SET_HR, add 1 to the hour on each increment press (23 wraps to 00), with minutes unaffected.
REQ-020 SHALL, in SET_MIN, add 1 to the minute on each increment press (59 wraps to 00), with no hour carry.
REQ-021 SHALL hold the prescaler at 0 and freeze sec while in SET_HR or SET_MIN.
REQ-022 SHALL, on the SET_MIN -> RUN transition, clear sec and the prescaler to 0.
REQ-023 SHALL ignore increment presses in RUN.
REQ-024 SHALL, when a mode press and an increment press occur in the same cycle, perform the mode transition only and leave the time unchanged.
REQ-025 SHALL toggle blink every BLINK_CYCLES cycles in set modes, starting at 0 on mode entry, and hold blink at 0 in RUN.
REQ-026 SHALL reflect a clean button press on mode or time 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge, with an allowed tolerance of ±1 cycle.

Reset
REQ-027 SHALL, while RESET_N=0, asynchronously force: all time digits 0, sec=0, LED=0, mode=RUN, blink=0, prescaler=0, blink counter=0, debouncer state=released, synchronizer flops=0.
REQ-028 SHALL, on reset assertion mid-operation (any state), discard any pending press and abandon any edit.
REQ-029 SHALL resume counting from 00:00:00 in RUN starting with the first clock edge after RESET_N rises.

Structure
REQ-030 SHALL place the mode enum (RUN/SET_HR/SET_MIN), the BCD limits (hours 23, minutes 59, seconds 59) and the mode-encoding constants in shared package wall_clock_pkg.
REQ-031 SHALL implement the synchronizer, debouncer and rise pulse as one sub-module, btn_debounce, instantiated twice.

Verification
All runs SHALL use CLK_HZ=10, DEBOUNCE_CYCLES=4 and BLINK_CYCLES=3.
REQ-032 Reset, then 600 cycles -> min_units=1, sec=0, LED=0, all other digits 0.
REQ-033 Mode press, 23 increment presses, mode press, 59 increment presses, mode press, then 600 cycles -> 00:00:00 with mode=RUN.
REQ-034 In SET_HR, 24 increment presses -> hr_tens=0, hr_units=0, minutes unchanged; blink toggles every 3 cycles, and blink=0 after return to RUN.
REQ-035 A 3-cycle high glitch on button[0], then a bouncing 0/1/0/1 burst ending high for 4 stable cycles -> exactly one mode change, RUN -> SET_HR.
REQ-036 Mode and increment presses accepted in the same cycle while in SET_HR -> mode=SET_MIN, hours and minutes unchanged.
REQ-037 RESET_N pulsed low in SET_MIN at time 12:34 -> outputs 0 within the same cycle, mode=RUN, and counting restarts at 00:00:00.
